// File: rtl/frame_seq.sv
// rtl/frame_seq.sv - RMII receive frame sequencer: delimit, length-check, drain/flush.
// Optional per-frame good/bad statistics counters enabled by FRAME_SEQ_STATS_EN.
module frame_seq #(
  parameter int MIN_BYTES    = 64,
  parameter int MAX_BYTES    = 1518,
  parameter int DRAIN_CYCLES = 4,
  parameter int GAP_CYCLES   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  input  logic [1:0]  axiid,
  output logic        axiov,
  output logic [1:0]  axiod,
  output logic        flush,
  output logic        frame_start,
  output logic        frame_done,
  output logic [1:0]  err,
  output logic [10:0] byte_cnt,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_FLUSH   = 3'd3;
  localparam logic [2:0] S_WAITLOW = 3'd4;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_RUNT  = 2'd1;
  localparam logic [1:0] ERR_GIANT = 2'd2;
  localparam logic [1:0] ERR_ALIGN = 2'd3;

  localparam logic [10:0] MIN_B      = 11'(MIN_BYTES);
  localparam logic [10:0] MAX_B      = 11'(MAX_BYTES);
  localparam logic [10:0] SAT_B      = 11'd2047;
  localparam logic [7:0]  DRAIN_LAST = 8'(DRAIN_CYCLES);
  localparam logic [7:0]  GAP_LAST   = 8'(GAP_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  phase_q, phase_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [1:0]  err_q, err_d;
  logic        giant_wait_q, giant_wait_d;
  logic        axiiv_prev_q, axiiv_prev_d;
  logic        axiov_q, axiov_d;
  logic [1:0]  axiod_q, axiod_d;
  logic        flush_q, flush_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_done_q, frame_done_d;
  logic        start_frame;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    phase_d       = phase_q;
    byte_cnt_d    = byte_cnt_q;
    err_d         = err_q;
    giant_wait_d  = giant_wait_q;
    axiiv_prev_d  = axiiv;
    axiov_d       = 1'b0;
    axiod_d       = 2'd0;
    flush_d       = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    start_frame   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (axiiv) start_frame = 1'b1;
      end
      S_RUN: begin
        if (axiiv) begin
          if (byte_cnt_q == MAX_B) begin
            err_d        = ERR_GIANT;
            giant_wait_d = 1'b1;
            state_d      = S_WAITLOW;
          end else begin
            axiov_d = 1'b1;
            axiod_d = axiid;
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd3 && byte_cnt_q != SAT_B) byte_cnt_d = byte_cnt_q + 11'd1;
          end
        end else begin
          frame_done_d = 1'b1;
          state_d      = S_DRAIN;
          cnt_d        = 8'd0;
          if (phase_q != 2'd0)        err_d = ERR_ALIGN;
          else if (byte_cnt_q < MIN_B) err_d = ERR_RUNT;
          else                         err_d = ERR_OK;
        end
      end
      // Giant frames report on the falling edge; mid-stream bursts exit silently.
      S_WAITLOW: begin
        if (!axiiv) begin
          giant_wait_d = 1'b0;
          if (giant_wait_q) begin
            frame_done_d = 1'b1;
            state_d      = S_DRAIN;
            cnt_d        = 8'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_FLUSH;
          cnt_d   = 8'd0;
          flush_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_FLUSH: begin
        flush_d = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        // Last gap cycle doubles as IDLE: a fresh rising axiiv starts a frame,
        // while one that was already high belongs to a discarded burst.
        if (cnt_q == GAP_LAST) begin
          flush_d = 1'b0;
          cnt_d   = 8'd0;
          if (axiiv && axiiv_prev_q) begin
            state_d      = S_WAITLOW;
            giant_wait_d = 1'b0;
          end else if (axiiv) begin
            start_frame = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_frame) begin
      state_d       = S_RUN;
      axiov_d       = 1'b1;
      axiod_d       = axiid;
      frame_start_d = 1'b1;
      phase_d       = 2'd1;
      byte_cnt_d    = 11'd0;
      err_d         = ERR_OK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 8'd0;
      phase_q       <= 2'd0;
      byte_cnt_q    <= 11'd0;
      err_q         <= ERR_OK;
      giant_wait_q  <= 1'b0;
      axiiv_prev_q  <= 1'b0;
      axiov_q       <= 1'b0;
      axiod_q       <= 2'd0;
      flush_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      byte_cnt_q    <= byte_cnt_d;
      err_q         <= err_d;
      giant_wait_q  <= giant_wait_d;
      axiiv_prev_q  <= axiiv_prev_d;
      axiov_q       <= axiov_d;
      axiod_q       <= axiod_d;
      flush_q       <= flush_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign axiov       = axiov_q;
  assign axiod       = axiod_q;
  assign flush       = flush_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign err         = err_q;
  assign byte_cnt    = byte_cnt_q;

`ifdef FRAME_SEQ_STATS_EN
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] bad_cnt_q, bad_cnt_d;

  always_comb begin
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (frame_done_q) begin
      if (err_q == ERR_OK) good_cnt_d = good_cnt_q + 16'd1;
      else                 bad_cnt_d  = bad_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_cnt_q <= 16'd0;
      bad_cnt_q  <= 16'd0;
    end else begin
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign good_cnt = good_cnt_q;
  assign bad_cnt  = bad_cnt_q;
`else
  assign good_cnt = 16'd0;
  assign bad_cnt  = 16'd0;
`endif

endmodule

// File: doc/frame_seq.md
# frame_seq

Receive-side frame sequencer for the RMII Ethernet path. Sits between the preamble-stripped dibit stream from the PHY front end and the downstream per-frame stages (dibit bit-order correction, firewall, checksum). It delimits each frame and forwards dibits only while a frame is legal. After each frame it gives the downstream stages a fixed drain window, then pulses their flush input. It reports per-frame byte count and error status.

## Interface
- MIN_BYTES, 64, minimum legal frame length in bytes (runt threshold)
- MAX_BYTES, 1518, maximum legal frame length in bytes (giant threshold)
- DRAIN_CYCLES, 4, cycles after frame end during which flush stays low so downstream stages can emit their tail
- GAP_CYCLES, 12, cycles flush is held high after the drain window
- clk  in  1  system clock, 50 MHz RMII domain
- rst  in  1  asynchronous, active-high reset
- axiiv  in  1  input dibit valid; frame in progress while high
- axiid  in  2  input dibit
- axiov  out  1  forwarded dibit valid
- axiod  out  2  forwarded dibit
- flush  out  1  synchronous clear to downstream stages
- frame_start  out  1  one-cycle pulse, first forwarded dibit of a frame
- frame_done  out  1  one-cycle pulse, frame ended; byte_cnt/err valid
- err  out  2  0 ok, 1 runt, 2 giant, 3 misaligned (dibit count not a multiple of 4); valid with frame_done, held until next frame_start
- byte_cnt  out  11  complete bytes received in the current/last frame, saturating at 2047
- good_cnt  out  16  frames ended with err=0 (see Configuration)
- bad_cnt  out  16  frames ended with err≠0 (see Configuration)

## Operation
- States: IDLE, RUN, DRAIN, FLUSH, WAITLOW.
- IDLE: axiiv=1 → RUN. The dibit is forwarded, frame_start is pulsed, and byte_cnt, the dibit phase and err are cleared.
- RUN: each axiiv=1 cycle forwards the dibit and advances the 2-bit phase. Phase 3→0 increments byte_cnt (saturating).
- RUN, giant: when a dibit arrives with byte_cnt already equal to MAX_BYTES, err=2 latches. That dibit and all later dibits are not forwarded. Next state is WAITLOW.
- WAITLOW: axiov=0. On axiiv=0 → DRAIN, and frame_done pulses with err=2.
- RUN, frame end: axiiv=0 → DRAIN, and frame_done pulses. err priority: misaligned (phase≠0) > runt (byte_cnt<MIN_BYTES) > ok.
- DRAIN: axiov=0, flush=0 for DRAIN_CYCLES cycles → FLUSH.
- FLUSH: flush=1 for GAP_CYCLES cycles → IDLE.
- axiiv=1 in DRAIN or FLUSH: the dibits are discarded and no frame_start is issued. If axiiv is still high on entry to IDLE, the block goes to WAITLOW; it does not start a frame mid-stream. This WAITLOW exit pulses no frame_done, and the good/bad counters are unchanged.
- Asynchronous reset: all outputs go to 0 and the state goes to IDLE, including mid-frame. No frame_done is issued for the aborted frame.

## Timing
- Forwarding latency is 1 cycle: axiov/axiod are registered copies of axiiv/axiid.
- frame_start is high in the same cycle as the first axiov=1.
- frame_done is high in the cycle after the first axiiv=0 sample, i.e. the cycle after the last axiov=1 for a normal frame.
- flush rises DRAIN_CYCLES+1 cycles after frame_done and stays high exactly GAP_CYCLES cycles.
- The earliest accepted next frame_start is GAP_CYCLES+DRAIN_CYCLES+1 cycles after frame_done.
- flush is never high while axiov=1.
- Reset values: axiov=0, axiod=0, flush=0, frame_start=0, frame_done=0, err=0, byte_cnt=0, good_cnt=0, bad_cnt=0.

## Configuration
- FRAME_SEQ_STATS_EN defined:
  - good_cnt/bad_cnt increment (wrap at 16 bits) in the cycle after each frame_done, per err.
  - Both reset to 0.
- FRAME_SEQ_STATS_EN undefined:
  - good_cnt/bad_cnt ports remain but are tied to 0.
  - No counter logic is synthesised.

## Test plan
- 256 dibits (64 bytes) then axiiv low → 256 forwarded dibits at 1-cycle latency; frame_start once; frame_done with err=0, byte_cnt=64; flush high for cycles +5..+16 after frame_done; good_cnt=1.
- 100 dibits (25 bytes) → err=1, byte_cnt=25, bad_cnt=1.
- 258 dibits → err=3, byte_cnt=64.
- 6200 dibits → exactly 6072 dibits forwarded (1518 bytes); axiov then low; frame_done only after axiiv falls, with err=2, byte_cnt=1518.
- Frame then a new axiiv burst starting 3 cycles after frame_done → burst discarded; no frame_start; WAITLOW until the burst ends; next clean frame accepted normally.
- Reset asserted at dibit 50 of a frame → all outputs 0 in the same cycle (asynchronous); no frame_done; the following frame counts from 0.
